// File: rtl/rs232_byte_tx.sv
// rs232_byte_tx -- FIFO-buffered RS-232 byte transmitter (8N1 / 8N2).
//
// Accepts single-cycle byte strobes from the upstream sender, buffers them
// in a small FIFO and serialises each byte as an asynchronous frame on TXD:
// start bit, 8 data bits LSB first, optional even parity bit, then 1 or 2
// stop bits. Frames are sent back-to-back while the FIFO has data.
//
// Optional feature: define RS232_PARITY_EN to insert an even-parity bit
// after the 8 data bits. Without it the frame is 8N1 / 8N2.
//
// Parameters:
//   CLKS_PER_BIT     clock cycles per bit period (4..65535)
//   FIFO_DEPTH_LOG2  log2 of the FIFO depth
//   STOP_BITS        number of stop bits (1 or 2)
//
// Ports:
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-low reset
//   SendData       in   byte to transmit, sampled with SendDataReady
//   SendDataReady  in   single-cycle push strobe
//   TXD            out  serial line, idles high (registered)
//   TX_BUSY        out  frame on the line or FIFO non-empty (registered)
//   FIFO_LEVEL     out  FIFO occupancy, 0..depth
//   FIFO_FULL      out  FIFO_LEVEL == depth
//   OVERFLOW       out  sticky flag, set when a push is dropped

module rs232_byte_tx #(
  parameter int unsigned CLKS_PER_BIT    = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [7:0]                 SendData,
  input  logic                       SendDataReady,
  output logic                       TXD,
  output logic                       TX_BUSY,
  output logic [FIFO_DEPTH_LOG2:0]   FIFO_LEVEL,
  output logic                       FIFO_FULL,
  output logic                       OVERFLOW
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [15:0]                  BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]                   STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [FIFO_DEPTH_LOG2-1:0]   PTR_ONE    = 1;
  localparam logic [FIFO_DEPTH_LOG2:0]     LVL_ONE    = 1;
  localparam logic [FIFO_DEPTH_LOG2:0]     LVL_ZERO   = '0;
  localparam logic [FIFO_DEPTH_LOG2:0]     LVL_FULL   = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

`ifdef RS232_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   level_q;
  logic [FIFO_DEPTH_LOG2:0]   level_d;
  logic                       ovf_q;

  // Transmitter
  state_t                     state_q;
  logic [15:0]                baud_q;
  logic [2:0]                 bit_idx_q;
  logic [7:0]                 shift_q;
  logic                       txd_q;
  logic                       busy_q;
  logic                       busy_d;
`ifdef RS232_PARITY_EN
  logic                       parity_q;
`endif

  logic fifo_empty;
  logic fifo_full;
  logic baud_end;
  logic stop_done;
  logic push_en;
  logic pop_en;
  logic fsm_idle_next;

  assign fifo_empty = (level_q == LVL_ZERO);
  assign fifo_full  = (level_q == LVL_FULL);
  assign baud_end   = (baud_q == BAUD_LAST);
  // Last cycle of the last stop bit: the frame ends on the coming edge.
  assign stop_done  = (state_q == S_STOP) && baud_end && (bit_idx_q == STOP_LAST);

  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign push_en = SendDataReady && !fifo_full;
  assign pop_en  = !fifo_empty && ((state_q == S_IDLE) || stop_done);

  // The FSM rests in IDLE after this edge only if nothing can be popped.
  assign fsm_idle_next = fifo_empty && ((state_q == S_IDLE) || stop_done);

  always_comb begin
    level_d = level_q;
    if (push_en && !pop_en) begin
      level_d = level_q + LVL_ONE;
    end else if (!push_en && pop_en) begin
      level_d = level_q - LVL_ONE;
    end
  end

  assign busy_d = !fsm_idle_next || (level_d != LVL_ZERO);

  // FIFO storage: no reset, contents are invalidated by the level counter.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= SendData;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      level_q <= level_d;
      if (SendDataReady && fifo_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Frame sequencer. TXD is updated on the same edge as each state/bit
  // transition so the line always reflects the bit currently being timed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef RS232_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      baud_q <= baud_q + 16'd1;

      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          txd_q  <= 1'b1;
          if (pop_en) begin
            shift_q   <= mem_q[rd_ptr_q];
`ifdef RS232_PARITY_EN
            parity_q  <= ^mem_q[rd_ptr_q];
`endif
            bit_idx_q <= '0;
            txd_q     <= 1'b0;
            state_q   <= S_START;
          end
        end

        S_START: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= S_DATA;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef RS232_PARITY_EN
              txd_q     <= parity_q;
              state_q   <= S_PARITY;
`else
              txd_q     <= 1'b1;
              state_q   <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end

`ifdef RS232_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            state_q   <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == STOP_LAST) begin
              bit_idx_q <= '0;
              if (pop_en) begin
                // Back-to-back: next start bit begins with no idle gap.
                shift_q  <= mem_q[rd_ptr_q];
`ifdef RS232_PARITY_EN
                parity_q <= ^mem_q[rd_ptr_q];
`endif
                txd_q    <= 1'b0;
                state_q  <= S_START;
              end else begin
                txd_q    <= 1'b1;
                state_q  <= S_IDLE;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end

        default: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          txd_q     <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign TXD        = txd_q;
  assign TX_BUSY    = busy_q;
  assign FIFO_LEVEL = level_q;
  assign FIFO_FULL  = fifo_full;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_rs232_byte_tx.sv
// Testbench for rs232_byte_tx. A timeline model predicts the line and FIFO
// status each cycle; a UART receiver decodes TXD and checks each frame
// against a queue of expected bytes filled when pushes are accepted.
module tb_rs232_byte_tx;

  localparam int CPB   = 16;
  localparam int LOG2  = 3;
  localparam int STOP  = 1;
  localparam int DEPTH = 1 << LOG2;
`ifdef RS232_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 1 + 8 + PAR + STOP;
  localparam int FRAME = NBITS * CPB;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [7:0]      SendData = 8'h00;
  logic            SendDataReady = 1'b0;
  logic            TXD;
  logic            TX_BUSY;
  logic [LOG2:0]   FIFO_LEVEL;
  logic            FIFO_FULL;
  logic            OVERFLOW;

  rs232_byte_tx #(
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH_LOG2(LOG2),
    .STOP_BITS      (STOP)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SendData     (SendData),
    .SendDataReady(SendDataReady),
    .TXD          (TXD),
    .TX_BUSY      (TX_BUSY),
    .FIFO_LEVEL   (FIFO_LEVEL),
    .FIFO_FULL    (FIFO_FULL),
    .OVERFLOW     (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model (timeline of the line) ----------------
  longint     cyc = 0;
  longint     next_free = 0;       // first edge at which a new frame may start
  longint     frame_start = -1000000;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] mq[$];               // model FIFO contents
  logic [7:0] exp_q[$];            // scoreboard: bytes expected on the line
  int         m_level = 0;
  bit         m_ovf = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_txd = 1'b1;
  int         lvl_before;
  bit         do_pop;
  bit         acc;
  int         peak_level = 0;
  int         rx_count = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[3'(pos - 1)];
    if (PAR == 1 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cyc         = 0;
      next_free   = 0;
      frame_start = -1000000;
      mq.delete();
      exp_q.delete();
      m_level     = 0;
      m_ovf       = 1'b0;
      m_busy      = 1'b0;
      m_txd       = 1'b1;
    end else begin
      cyc++;
      lvl_before = mq.size();
      do_pop     = (lvl_before > 0) && (cyc >= next_free);
      acc        = SendDataReady && (lvl_before < DEPTH);
      if (SendDataReady && !acc) m_ovf = 1'b1;
      if (do_pop) begin
        cur_byte    = mq.pop_front();
        frame_start = cyc;
        next_free   = cyc + FRAME;
      end
      if (acc) begin
        mq.push_back(SendData);
        exp_q.push_back(SendData);
      end
      m_level = mq.size();
      m_busy  = (cyc < next_free) || (m_level != 0);
      if (cyc < next_free) m_txd = frame_bit(cur_byte, int'((cyc - frame_start) / CPB));
      else                 m_txd = 1'b1;
    end
  end

  // Per-cycle status comparison, away from the active edge.
  always @(negedge CLK) begin
    if (RST) begin
      check("txd",        TXD,        m_txd);
      check("fifo_level", FIFO_LEVEL, m_level);
      check("fifo_full",  FIFO_FULL,  m_level == DEPTH);
      check("overflow",   OVERFLOW,   m_ovf);
      check("tx_busy",    TX_BUSY,    m_busy);
      if (int'(FIFO_LEVEL) > peak_level) peak_level = int'(FIFO_LEVEL);
    end
  end

  // ---------------- monitor: UART receiver + scoreboard ----------------
  bit          rx_active = 1'b0;
  int          rx_cnt = 0;
  int          rx_k;
  logic [15:0] rx_bits = '0;
  logic [7:0]  rx_exp;

  always @(negedge CLK) begin
    if (!RST) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active) begin
        if (TXD == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          rx_bits   = '0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_active && (rx_cnt % CPB) == CPB / 2) begin
        rx_k = rx_cnt / CPB;
        rx_bits[4'(rx_k)] = TXD;
        if (rx_k == NBITS - 1) begin
          rx_active = 1'b0;
          rx_count++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_unexpected: got frame 0x%02h, required no frame", rx_bits[8:1]);
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_start", rx_bits[0], 0);
            check("rx_data", rx_bits[8:1], rx_exp);
            if (PAR == 1) check("rx_parity", rx_bits[9], ^rx_exp);
            for (int s = 0; s < STOP; s++) check("rx_stop", rx_bits[4'(9 + PAR + s)], 1);
            $display("rx frame %0d: byte 0x%02h expected 0x%02h (cycle %0d)",
                     rx_count, rx_bits[8:1], rx_exp, cyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_cycle(input logic v, input logic [7:0] d);
    @(posedge CLK);
    #1;
    SendDataReady = v;
    SendData      = d;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(mq.size() == 0 && cyc >= next_free) && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: timeout after %0d cycles, required drain", n);
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  longint target;
  int     n_wait;
  int     rx_before;

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_txd",   TXD, 1);
    check("rst_busy",  TX_BUSY, 0);
    check("rst_level", FIFO_LEVEL, 0);
    check("rst_full",  FIFO_FULL, 0);
    check("rst_ovf",   OVERFLOW, 0);
    @(posedge CLK);
    #2;
    RST = 1'b1;

    // Single byte 0xA5 and two-edge latency
    drive_cycle(1'b1, 8'hA5);
    drive_cycle(1'b0, 8'h00);
    check("lat_e1_txd",   TXD, 1);
    check("lat_e1_level", FIFO_LEVEL, 1);
    check("lat_e1_busy",  TX_BUSY, 1);
    @(posedge CLK);
    #1;
    check("lat_e2_txd", TXD, 0);
    wait_idle(4 * FRAME);

    // Upstream burst: 8 bytes spaced 8 bit-times apart
    peak_level = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 8'(i));
      drive_cycle(1'b0, 8'h00);
      repeat (8 * CPB - 2) @(posedge CLK);
    end
    wait_idle(12 * FRAME);
    check("burst_peak", peak_level, 2);
    check("burst_ovf",  OVERFLOW, 0);

    // Random bytes with random gaps
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 8'($urandom));
      drive_cycle(1'b0, 8'h00);
      repeat ($urandom_range(FRAME / 4, 2 * FRAME)) @(posedge CLK);
    end
    wait_idle(16 * FRAME);

    // Push on the pop edge at the end of STOP with one byte queued
    drive_cycle(1'b1, 8'($urandom));
    drive_cycle(1'b1, 8'($urandom));
    drive_cycle(1'b0, 8'h00);
    target = next_free;
    n_wait = 0;
    while (cyc != target - 2 && n_wait < 2 * FRAME) begin
      @(posedge CLK);
      #1;
      n_wait++;
    end
    check("simul_wait", cyc, target - 2);
    drive_cycle(1'b1, 8'($urandom));
    drive_cycle(1'b0, 8'h00);
    check("simul_level", FIFO_LEVEL, 1);
    check("simul_txd",   TXD, 0);
    wait_idle(6 * FRAME);

    // Overflow: 10 consecutive pushes
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'(8'h10 + i));
    drive_cycle(1'b0, 8'h00);
    check("ovf_full", FIFO_FULL, 1);
    check("ovf_set",  OVERFLOW, 1);
    wait_idle(14 * FRAME);
    check("ovf_sticky", OVERFLOW, 1);

    // Reset during data bit 3 with bytes queued
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'($urandom));
    drive_cycle(1'b0, 8'h00);
    n_wait = 0;
    while (cyc != frame_start + 4 * CPB + 3 && n_wait < 2 * FRAME) begin
      @(posedge CLK);
      #1;
      n_wait++;
    end
    check("rstmid_wait", cyc - frame_start, 4 * CPB + 3);
    check("rstmid_txd_pre", TXD, frame_bit(cur_byte, 4));
    #1;
    RST = 1'b0;
    #1;
    check("rstmid_txd",   TXD, 1);
    check("rstmid_level", FIFO_LEVEL, 0);
    check("rstmid_busy",  TX_BUSY, 0);
    check("rstmid_full",  FIFO_FULL, 0);
    check("rstmid_ovf",   OVERFLOW, 0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    rx_before = rx_count;
    repeat (3 * FRAME) @(posedge CLK);
    #1;
    check("rstmid_no_frame", rx_count - rx_before, 0);
    drive_cycle(1'b1, 8'($urandom));
    drive_cycle(1'b0, 8'h00);
    wait_idle(4 * FRAME);

    // Parity patterns (parity bit checked by the monitor when enabled)
    drive_cycle(1'b1, 8'h07);
    drive_cycle(1'b0, 8'h00);
    wait_idle(4 * FRAME);
    drive_cycle(1'b1, 8'h03);
    drive_cycle(1'b0, 8'h00);
    wait_idle(4 * FRAME);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs232_byte_tx.md
Name: rs232_byte_tx

Overview:
- Downstream consumer of the DES/Trojan top's byte stream: takes SendData/SendDataReady strobes and serialises them as 8N1 RS-232 frames on TXD.
- An 8-entry FIFO decouples the upstream byte cadence from the line rate.
- The upstream pushes one byte every ~6945 cycles, which is shorter than one frame at 10 x 868 cycles. The FIFO absorbs the full 8-byte ciphertext burst without loss.
- Sits between the top-level sender and the board UART pin.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per bit (100 MHz / 115200); legal range 4..65535
- FIFO_DEPTH_LOG2, 3, log2 of FIFO depth (8 entries)
- STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
- CLK  in  1  system clock, all logic rising-edge
- RST  in  1  asynchronous, active-low reset
- SendData  in  8  byte to transmit; sampled when SendDataReady=1
- SendDataReady  in  1  single-cycle push strobe
- TXD  out  1  serial line; idles high
- TX_BUSY  out  1  high while a frame is on the line or the FIFO is non-empty
- FIFO_LEVEL  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy, 0..8
- FIFO_FULL  out  1  FIFO_LEVEL == depth
- OVERFLOW  out  1  sticky; set when a push is dropped

Behaviour:
- Reset (RST=0, asynchronous):
  - TXD=1, TX_BUSY=0, FIFO_LEVEL=0, FIFO_FULL=0, OVERFLOW=0.
  - FSM goes to IDLE; bit counter and baud counter are cleared.
  - Reset mid-frame aborts the frame immediately; TXD returns high that same instant. FIFO contents are discarded.
- Push:
  - Occurs on a CLK edge with SendDataReady=1 and FIFO_FULL=0.
  - SendData is written at the write pointer; FIFO_LEVEL is incremented on that edge.
  - If FIFO_FULL=1, the byte is dropped and OVERFLOW is set. This applies even if a pop happens in the same cycle.
  - OVERFLOW clears only on reset.
- Pop:
  - FSM in IDLE and FIFO_LEVEL != 0: the head byte is loaded into the shift register on the next edge, the read pointer advances and FIFO_LEVEL is decremented.
  - Simultaneous push and pop: FIFO_LEVEL is unchanged.
- Pointers: binary, wrap modulo depth. Full and empty are derived from the level counter, not from pointer compare.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: TXD=1; leaves on pop.
  - START: TXD=0 for CLKS_PER_BIT cycles.
  - DATA: LSB first, 8 bits, each held CLKS_PER_BIT cycles. A 3-bit index increments at the end of each bit period and DATA exits after bit 7.
  - PARITY: present only with the option enabled.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of STOP: if the FIFO is non-empty, pop and go straight to START with no idle gap (back-to-back frames); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state or bit transition. Bit timing is exact, with no drift across frames.
- Latency: SendDataReady edge into an empty FIFO with the FSM in IDLE -> TXD falls 2 CLK edges later (edge 1 push, edge 2 pop into START).
- TX_BUSY = (FSM != IDLE) | (FIFO_LEVEL != 0), registered. It deasserts on the edge that returns the FSM to IDLE with an empty FIFO.
- TXD is driven from a register; no combinational path from inputs.

Optional Feature:
- Macro: RS232_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA, duration CLKS_PER_BIT.
  - TXD = XOR of the 8 data bits (even parity).
  - Frame is 11 bits (12 with STOP_BITS=2).
- Undefined:
  - No PARITY state and no parity logic; frame is 8N1/8N2.

Test Plan:
- Single byte:
  - Stimulus: push 0xA5 with CLKS_PER_BIT=868.
  - Response: TXD falls 2 cycles later, then carries 0,1,0,1,0,0,1,0,1,1 at 868-cycle intervals. TX_BUSY drops after 8680 cycles plus latency.
- Upstream burst:
  - Stimulus: 8 pushes 0x00..0x07, spaced 6945 cycles.
  - Response: all 8 frames are sent in order back-to-back with no idle between stop and start. Peak FIFO_LEVEL=2; OVERFLOW stays 0.
- Overflow:
  - Stimulus: 10 pushes on consecutive cycles, 0x10..0x19.
  - Response:
    - First byte popped immediately; FIFO_FULL asserts after the 9th push; the 10th byte (0x19) is dropped and OVERFLOW=1.
    - 0x10..0x18 are transmitted; OVERFLOW stays 1 after the FIFO drains.
- Simultaneous push/pop:
  - Stimulus: push timed on the pop edge at the end of STOP with FIFO_LEVEL=1.
  - Response: FIFO_LEVEL stays 1 and both bytes are transmitted in order.
- Reset mid-frame:
  - Stimulus: assert RST=0 during DATA bit 3 with 3 bytes queued.
  - Response: TXD=1, FIFO_LEVEL=0, TX_BUSY=0 immediately (asynchronous). After release, no frame is sent until a new push.
- Parity (RS232_PARITY_EN):
  - Stimulus: push 0x07.
  - Response: parity bit=1 after bit 7, then stop bit(s).
  - Stimulus: push 0x03.
  - Response: parity bit=0.
